// File: rtl/uart_cpld_tx.sv
// Transmit controller for the CPLD UART: buffers bytes in a small FIFO and plays
// each one out with the uart_wrn strobe, then waits for the tbre/tsre completion flags.
module uart_cpld_tx #(
   parameter int unsigned FIFO_DEPTH     = 8,
   parameter int unsigned WRN_LOW_CYCLES = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic [7:0]                    wr_data,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          busy,
   output logic                          overflow,
   output logic                          sent,
   output logic                          uart_wrn,
   output logic [7:0]                    uart_data_o,
   output logic                          uart_data_oe,
   input  logic                          uart_tbre,
   input  logic                          uart_tsre
);

   localparam int unsigned AW  = $clog2(FIFO_DEPTH);
   localparam int unsigned PW  = AW + 1;
   localparam int unsigned SCW = (WRN_LOW_CYCLES > 1) ? $clog2(WRN_LOW_CYCLES) : 1;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_SETUP     = 3'd1;
   localparam logic [2:0] S_STROBE    = 3'd2;
   localparam logic [2:0] S_HOLD      = 3'd3;
   localparam logic [2:0] S_WAIT_TBRE = 3'd4;
   localparam logic [2:0] S_WAIT_TSRE = 3'd5;

   logic [2:0]     state_q, state_d;
   logic [SCW-1:0] strb_cnt_q, strb_cnt_d;
   logic [7:0]     tx_byte_q, tx_byte_d;
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]  count_q, count_d;
   logic           full_q, full_d;
   logic           empty_q, empty_d;
   logic           overflow_q, overflow_d;
   logic           sent_q, sent_d;
   logic           busy_q, busy_d;
   logic           wrn_q, wrn_d;
   logic           oe_q, oe_d;
   logic [7:0]     mem_q [FIFO_DEPTH];
   logic           push;
   logic           pop;

   // FIFO pointer/occupancy next state; full blocks a push even when popping
   always_comb begin
      push       = wr_en && !full_q;
      overflow_d = overflow_q | (wr_en & full_q);
      wr_ptr_d   = wr_ptr_q + PW'(push);
      rd_ptr_d   = rd_ptr_q + PW'(pop);
      count_d    = wr_ptr_d - rd_ptr_d;
      full_d     = (count_d == PW'(FIFO_DEPTH));
      empty_d    = (count_d == '0);
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
      end
   end

   // Byte sequencer; pin controls are decoded from the next state so they register in step
   always_comb begin
      state_d    = state_q;
      strb_cnt_d = strb_cnt_q;
      tx_byte_d  = tx_byte_q;
      pop        = 1'b0;
      sent_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!empty_q) begin
               pop       = 1'b1;
               tx_byte_d = mem_q[rd_ptr_q[AW-1:0]];
               state_d   = S_SETUP;
            end
         end
         S_SETUP: begin
            strb_cnt_d = '0;
            state_d    = S_STROBE;
         end
         S_STROBE: begin
            if (strb_cnt_q == SCW'(WRN_LOW_CYCLES - 1)) begin
               strb_cnt_d = '0;
               state_d    = S_HOLD;
            end else begin
               strb_cnt_d = strb_cnt_q + SCW'(1);
            end
         end
         S_HOLD: begin
            state_d = S_WAIT_TBRE;
         end
         S_WAIT_TBRE: begin
            if (uart_tbre) begin
               state_d = S_WAIT_TSRE;
            end
         end
         S_WAIT_TSRE: begin
            if (uart_tsre) begin
               sent_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      wrn_d  = (state_d != S_STROBE);
      oe_d   = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         strb_cnt_q <= '0;
         tx_byte_q  <= 8'h00;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
         sent_q     <= 1'b0;
         busy_q     <= 1'b0;
         wrn_q      <= 1'b1;
         oe_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         strb_cnt_q <= strb_cnt_d;
         tx_byte_q  <= tx_byte_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         overflow_q <= overflow_d;
         sent_q     <= sent_d;
         busy_q     <= busy_d;
         wrn_q      <= wrn_d;
         oe_q       <= oe_d;
      end
   end

   assign full         = full_q;
   assign empty        = empty_q;
   assign count        = count_q;
   assign busy         = busy_q;
   assign overflow     = overflow_q;
   assign sent         = sent_q;
   assign uart_wrn     = wrn_q;
   assign uart_data_o  = tx_byte_q;
   assign uart_data_oe = oe_q;

endmodule

// File: tb/tb_uart_cpld_tx.sv
// Bench for uart_cpld_tx: a byte-queue model timed by age-since-pop, compared every
// cycle, plus directed scenarios with literal expectations.
module tb_uart_cpld_tx;

   localparam int DEPTH = 8;
   localparam int W     = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full;
   logic       empty;
   logic [3:0] count;
   logic       busy;
   logic       overflow;
   logic       sent;
   logic       uart_wrn;
   logic [7:0] uart_data_o;
   logic       uart_data_oe;
   logic       uart_tbre;
   logic       uart_tsre;

   uart_cpld_tx #(.FIFO_DEPTH(DEPTH), .WRN_LOW_CYCLES(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .full         (full),
      .empty        (empty),
      .count        (count),
      .busy         (busy),
      .overflow     (overflow),
      .sent         (sent),
      .uart_wrn     (uart_wrn),
      .uart_data_o  (uart_data_o),
      .uart_data_oe (uart_data_oe),
      .uart_tbre    (uart_tbre),
      .uart_tsre    (uart_tsre)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model state: queued bytes, byte in flight and its age in cycles since the pop
   logic [7:0] mq[$];
   logic [7:0] m_cur;
   bit         m_busy;
   int         m_age;
   bit         m_tbre_ok;
   bit         m_ovf;
   bit         m_sent;
   bit         m_valid = 1'b0;
   int         cyc = 0;

   int         strobes = 0;
   int         low_cycles = 0;
   logic       prev_wrn = 1'b1;
   logic [7:0] emitted[$];

   always @(posedge clk) begin
      int pre_size;
      bit was_busy;
      bit done;
      bit e_wrn;
      bit e_oe;
      cyc++;
      if (rst) begin
         mq.delete();
         m_cur     = 8'h00;
         m_busy    = 1'b0;
         m_age     = 0;
         m_tbre_ok = 1'b0;
         m_ovf     = 1'b0;
         m_sent    = 1'b0;
         m_valid   = 1'b1;
      end else begin
         pre_size = mq.size();
         was_busy = m_busy;
         done     = 1'b0;
         m_sent   = 1'b0;
         if (was_busy) begin
            if (m_age >= W + 2) begin
               if (!m_tbre_ok) begin
                  if (uart_tbre) m_tbre_ok = 1'b1;
               end else if (uart_tsre) begin
                  done = 1'b1;
               end
            end
            m_age++;
         end
         if (done) begin
            m_busy = 1'b0;
            m_sent = 1'b1;
         end
         if (!was_busy && pre_size > 0) begin
            m_cur     = mq.pop_front();
            m_busy    = 1'b1;
            m_age     = 0;
            m_tbre_ok = 1'b0;
         end
         if (wr_en) begin
            if (pre_size == DEPTH) m_ovf = 1'b1;
            else mq.push_back(wr_data);
         end
      end
      #1;
      if (m_valid) begin
         e_wrn = !(m_busy && m_age >= 1 && m_age <= W);
         e_oe  = m_busy && m_age <= W + 1;
         chk("wrn",      32'(uart_wrn),     32'(e_wrn));
         chk("oe",       32'(uart_data_oe), 32'(e_oe));
         chk("data",     32'(uart_data_o),  32'(m_cur));
         chk("busy",     32'(busy),         32'(m_busy));
         chk("sent",     32'(sent),         32'(m_sent));
         chk("count",    32'(count),        32'(mq.size()));
         chk("full",     32'(full),         32'(mq.size() == DEPTH));
         chk("empty",    32'(empty),        32'(mq.size() == 0));
         chk("overflow", 32'(overflow),     32'(m_ovf));
         if (prev_wrn === 1'b1 && uart_wrn === 1'b0) begin
            strobes++;
            emitted.push_back(uart_data_o);
         end
         if (uart_wrn === 1'b0) low_cycles++;
         prev_wrn = uart_wrn;
      end
   end

   task automatic wait_sent(input int bound, output int when);
      when = -1;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (sent === 1'b1) begin
            when = cyc;
            return;
         end
      end
      chk("sent_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_drain(input int bound, input int want);
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (emitted.size() >= want && busy === 1'b0 && empty === 1'b1) return;
      end
      chk("drain_timeout", 32'd0, 32'd1);
   endtask

   task automatic push_byte(input logic [7:0] b);
      wr_data = b;
      wr_en   = 1'b1;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   initial begin
      int push_cyc;
      int sent_cyc;
      int s0;
      int l0;
      int base;
      rst       = 1'b1;
      wr_en     = 1'b1;
      wr_data   = 8'hAA;
      uart_tbre = 1'b1;
      uart_tsre = 1'b1;

      // reset held two cycles while wr_en is asserted
      repeat (2) @(negedge clk);
      rst   = 1'b0;
      wr_en = 1'b0;
      chk("rst_wrn",      32'(uart_wrn),     32'd1);
      chk("rst_oe",       32'(uart_data_oe), 32'd0);
      chk("rst_empty",    32'(empty),        32'd1);
      chk("rst_count",    32'(count),        32'd0);
      chk("rst_overflow", 32'(overflow),     32'd0);
      repeat (2) @(negedge clk);

      // single byte with flags already high
      s0 = strobes;
      l0 = low_cycles;
      push_byte(8'h5A);
      push_cyc = cyc;
      wait_sent(30, sent_cyc);
      chk("single_latency", 32'(sent_cyc - push_cyc), 32'd7);
      @(negedge clk);
      chk("single_busy",    32'(busy),               32'd0);
      chk("single_strobes", 32'(strobes - s0),       32'd1);
      chk("single_low",     32'(low_cycles - l0),    32'd2);
      chk("single_byte",    32'(emitted[emitted.size()-1]), 32'h5A);

      // handshake stall
      uart_tbre = 1'b0;
      uart_tsre = 1'b0;
      s0 = strobes;
      push_byte(8'h31);
      repeat (5) @(negedge clk);
      chk("stall_oe",   32'(uart_data_oe), 32'd0);
      chk("stall_busy", 32'(busy),         32'd1);
      repeat (10) @(negedge clk);
      uart_tbre = 1'b1;
      repeat (5) @(negedge clk);
      chk("stall_nosent", 32'(sent), 32'd0);
      uart_tsre = 1'b1;
      @(negedge clk);
      chk("stall_sent",    32'(sent),         32'd1);
      chk("stall_strobes", 32'(strobes - s0), 32'd1);
      chk("stall_byte",    32'(emitted[emitted.size()-1]), 32'h31);
      @(negedge clk);

      // burst into a stalled transmitter: 00 in flight, 01..08 fill, 09 dropped
      uart_tbre = 1'b0;
      uart_tsre = 1'b0;
      base = emitted.size();
      for (int i = 0; i < 10; i++) begin
         wr_data = 8'(i);
         wr_en   = 1'b1;
         @(negedge clk);
      end
      wr_en = 1'b0;
      chk("burst_count",    32'(count),    32'd8);
      chk("burst_full",     32'(full),     32'd1);
      chk("burst_overflow", 32'(overflow), 32'd1);
      uart_tbre = 1'b1;
      uart_tsre = 1'b1;
      wait_drain(200, base + 9);
      chk("burst_emitted", 32'(emitted.size() - base), 32'd9);
      for (int k = 0; k < 9; k++) begin
         if (base + k < emitted.size()) chk("burst_order", 32'(emitted[base+k]), 32'(k));
      end
      @(negedge clk);

      // push lands in the same cycle as the pop of the previous byte
      base = emitted.size();
      push_byte(8'hC3);
      push_byte(8'h3C);
      chk("pp_count", 32'(count), 32'd1);
      chk("pp_busy",  32'(busy),  32'd1);
      wait_drain(60, base + 2);
      if (emitted.size() >= base + 2) begin
         chk("pp_first",  32'(emitted[base]),   32'hC3);
         chk("pp_second", 32'(emitted[base+1]), 32'h3C);
      end else begin
         chk("pp_emitted", 32'(emitted.size() - base), 32'd2);
      end
      @(negedge clk);

      // reset while the strobe is low with three bytes queued
      push_byte(8'h11);
      push_byte(8'h22);
      push_byte(8'h33);
      push_byte(8'h44);
      chk("mid_wrn",   32'(uart_wrn), 32'd0);
      chk("mid_count", 32'(count),    32'd3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_wrn",   32'(uart_wrn),     32'd1);
      chk("mid_rst_oe",    32'(uart_data_oe), 32'd0);
      chk("mid_rst_empty", 32'(empty),        32'd1);
      s0 = strobes;
      repeat (15) @(negedge clk);
      chk("mid_no_strobe", 32'(strobes - s0), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule
